mac16_seq_ctrl: RTL



---
 rtl/mac16_seq_ctrl_if.sv | 25 ++
 rtl/mac16_seq_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mac16_seq_ctrl_if.sv
// Operand and result handshake bundle for the sequential 16x16 MAC.
// The producer/consumer side uses master; the MAC itself uses slave.
interface mac16_seq_ctrl_if #(
  parameter int ACC_W = 40
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic             in_clr;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_prod;
  logic [ACC_W-1:0] out_acc;

  modport master (
    output in_valid, in_a, in_b, in_clr, out_ready,
    input  in_ready, out_valid, out_prod, out_acc
  );

  modport slave (
    input  in_valid, in_a, in_b, in_clr, out_ready,
    output in_ready, out_valid, out_prod, out_acc
  );
endinterface

// File: rtl/mac16_seq_ctrl.sv
// Iterative 16x16 unsigned MAC: one shared 8x8 multiplier is stepped over the
// four partial products, then the 32-bit product is added into a wrapping accumulator.

module wm (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  assign p = a * b;
endmodule

module mac16_seq_ctrl #(
  parameter int ACC_W = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  mac16_seq_ctrl_if.slave         bus,
  output logic                    busy
);
  typedef enum logic [1:0] {IDLE, PP, ACC, OUT} state_t;

  state_t           state_q, state_d;
  logic [1:0]       cnt_q;
  logic [15:0]      a_q, b_q;
  logic             clr_q;
  logic [31:0]      psum_q, psum_d;
  logic [31:0]      prod_q;
  logic [ACC_W-1:0] acc_q, acc_d;

  logic [7:0]       mul_a, mul_b;
  logic [15:0]      pp;
  logic [4:0]       shamt;
  logic [31:0]      pp_sh;

  logic             in_ready_c, out_valid_c, busy_c;

  // cnt bit 0 picks the high byte of a, bit 1 the high byte of b.
  always_comb begin
    mul_a = cnt_q[0] ? a_q[15:8] : a_q[7:0];
    mul_b = cnt_q[1] ? b_q[15:8] : b_q[7:0];
    case (cnt_q)
      2'd0:    shamt = 5'd0;
      2'd3:    shamt = 5'd16;
      default: shamt = 5'd8;
    endcase
  end

  wm u_wm (
    .a (mul_a),
    .b (mul_b),
    .p (pp)
  );

  // Every partial sum is bounded by the final 32-bit product, so 32 bits never overflow.
  always_comb begin
    pp_sh  = 32'(pp) << shamt;
    psum_d = psum_q + pp_sh;
    acc_d  = (clr_q ? '0 : acc_q) + ACC_W'(psum_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = PP;
      PP:      if (cnt_q == 2'd3) state_d = ACC;
      ACC:     state_d = OUT;
      OUT:     if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c  = (state_q == IDLE);
    out_valid_c = (state_q == OUT);
    busy_c      = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      clr_q  <= 1'b0;
      psum_q <= '0;
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q    <= bus.in_a;
            b_q    <= bus.in_b;
            clr_q  <= bus.in_clr;
            psum_q <= '0;
            cnt_q  <= '0;
          end
        end
        PP: begin
          psum_q <= psum_d;
          cnt_q  <= cnt_q + 2'd1;
        end
        ACC: begin
          acc_q  <= acc_d;
          prod_q <= psum_q;
        end
        default: ;
      endcase
    end
  end

  // prod_q and acc_q only change in ACC, so the result holds through backpressure.
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_prod  = prod_q;
  assign bus.out_acc   = acc_q;
  assign busy          = busy_c;
endmodule
